// File: rtl/vga_overlay_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_overlay_ctrl_if
// Bundles the overlay-controller bus: box configuration and background pixel
// in from the frame-buffer side, DAC colour/sync/fetch/coordinates out.
//   master : the controller (drives VGA_*, REQUEST_DATA, SCREEN_*, FRAME_START)
//   slave  : the environment (drives BOX_* and VGA_*_IN)
// ---------------------------------------------------------------------------
interface vga_overlay_ctrl_if #(
    parameter int unsigned NUM_BOXES = 4
);
    logic [NUM_BOXES-1:0]    BOX_ENABLE;
    logic [NUM_BOXES-1:0]    BOX_MODE;
    logic [10*NUM_BOXES-1:0] BOX_LEFT;
    logic [10*NUM_BOXES-1:0] BOX_TOP;
    logic [10*NUM_BOXES-1:0] BOX_RIGHT;
    logic [10*NUM_BOXES-1:0] BOX_BOTTOM;
    logic [24*NUM_BOXES-1:0] BOX_COLOR;
    logic [7:0]              VGA_R_IN;
    logic [7:0]              VGA_G_IN;
    logic [7:0]              VGA_B_IN;
    logic [7:0]              VGA_R;
    logic [7:0]              VGA_G;
    logic [7:0]              VGA_B;
    logic                    VGA_BLANK_N;
    logic                    VGA_SYNC_N;
    logic                    VGA_HS;
    logic                    VGA_VS;
    logic                    REQUEST_DATA;
    logic [9:0]              SCREEN_X;
    logic [9:0]              SCREEN_Y;
    logic                    FRAME_START;

    modport master (
        input  BOX_ENABLE, BOX_MODE, BOX_LEFT, BOX_TOP, BOX_RIGHT, BOX_BOTTOM,
        input  BOX_COLOR, VGA_R_IN, VGA_G_IN, VGA_B_IN,
        output VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_SYNC_N, VGA_HS, VGA_VS,
        output REQUEST_DATA, SCREEN_X, SCREEN_Y, FRAME_START
    );

    modport slave (
        output BOX_ENABLE, BOX_MODE, BOX_LEFT, BOX_TOP, BOX_RIGHT, BOX_BOTTOM,
        output BOX_COLOR, VGA_R_IN, VGA_G_IN, VGA_B_IN,
        input  VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_SYNC_N, VGA_HS, VGA_VS,
        input  REQUEST_DATA, SCREEN_X, SCREEN_Y, FRAME_START
    );
endinterface

// File: rtl/vga_overlay_ctrl.sv
// ---------------------------------------------------------------------------
// vga_overlay_ctrl
// VGA timing generator with look-ahead pixel fetch and an N-box prioritised
// colour overlay (fill or outline), box geometry shadowed per frame.
// Ports:
//   VGA_CLK  : pixel clock
//   RESET_N  : synchronous active-low reset
//   bus      : vga_overlay_ctrl_if.master (box config, background pixel in;
//              RGB, blank, sync, fetch strobe, coordinates, frame pulse out)
// All outputs are registered one cycle behind the h/v counters.
// ---------------------------------------------------------------------------
module vga_overlay_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned NUM_BOXES  = 4,
    parameter int unsigned BORDER_W   = 2,
    parameter int unsigned FETCH_LEAD = 2
) (
    input  logic               VGA_CLK,
    input  logic               RESET_N,
    vga_overlay_ctrl_if.master bus
);

    localparam int unsigned CW     = 10;
    localparam int unsigned CW1    = CW + 1;
    localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
    localparam int unsigned HS_END = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
    localparam int unsigned VS_END = VS_BEG + V_SYNC;
    // Request is registered, so it must look one position further than the lead.
    localparam int unsigned LOOK   = FETCH_LEAD + 1;
    localparam int unsigned GW     = 10 * NUM_BOXES;
    localparam int unsigned CLW    = 24 * NUM_BOXES;

    logic [CW-1:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic                 line_end_c, frame_end_c;
    logic [CW1-1:0]       h_look_sum_c;
    logic [CW-1:0]        h_look_c, v_look_c;
    logic                 active_c;

    logic [NUM_BOXES-1:0] sh_en_q, sh_mode_q;
    logic [GW-1:0]        sh_left_q, sh_top_q, sh_right_q, sh_bottom_q;
    logic [CLW-1:0]       sh_color_q;
    logic [NUM_BOXES-1:0] hit_c;
    logic [23:0]          pix_c;

    logic [23:0]          rgb_q, rgb_d;
    logic                 blank_n_q, blank_n_d;
    logic                 hs_q, hs_d, vs_q, vs_d;
    logic                 req_q, req_d;
    logic                 fs_q, fs_d;
    logic [CW-1:0]        sx_q, sy_q;

    // Raster counters, fetch look-ahead and next-state of the timing outputs.
    always_comb begin
        line_end_c  = (hcnt_q == CW'(H_TOT - 1));
        frame_end_c = line_end_c && (vcnt_q == CW'(V_TOT - 1));

        hcnt_d = line_end_c ? '0 : hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
        if (line_end_c) begin
            vcnt_d = frame_end_c ? '0 : vcnt_q + CW'(1);
        end

        // Look-ahead position wraps into the next line, and from the last line into line 0.
        h_look_sum_c = {1'b0, hcnt_q} + CW1'(LOOK);
        if (h_look_sum_c >= CW1'(H_TOT)) begin
            h_look_c = CW'(h_look_sum_c - CW1'(H_TOT));
            v_look_c = (vcnt_q == CW'(V_TOT - 1)) ? '0 : vcnt_q + CW'(1);
        end else begin
            h_look_c = CW'(h_look_sum_c);
            v_look_c = vcnt_q;
        end

        active_c  = (hcnt_q < CW'(H_ACTIVE)) && (vcnt_q < CW'(V_ACTIVE));
        blank_n_d = active_c;
        hs_d      = ((hcnt_q >= CW'(HS_BEG)) && (hcnt_q < CW'(HS_END))) ? HS_POL : ~HS_POL;
        vs_d      = ((vcnt_q >= CW'(VS_BEG)) && (vcnt_q < CW'(VS_END))) ? VS_POL : ~VS_POL;
        req_d     = (h_look_c < CW'(H_ACTIVE)) && (v_look_c < CW'(V_ACTIVE));
        fs_d      = (hcnt_q == '0) && (vcnt_q == '0);
    end

    // Per-box hit test against the shadow geometry; inverted bounds never match.
    for (genvar gi = 0; gi < int'(NUM_BOXES); gi++) begin : g_box
        logic [CW-1:0] left_c, top_c, right_c, bottom_c;
        logic          in_box_c, on_edge_c;

        assign left_c    = sh_left_q[10*gi +: 10];
        assign top_c     = sh_top_q[10*gi +: 10];
        assign right_c   = sh_right_q[10*gi +: 10];
        assign bottom_c  = sh_bottom_q[10*gi +: 10];
        assign in_box_c  = (hcnt_q >= left_c) && (hcnt_q <= right_c) &&
                           (vcnt_q >= top_c)  && (vcnt_q <= bottom_c);
        // Differences are only meaningful when in_box_c holds, which gates them.
        assign on_edge_c = ((hcnt_q - left_c)   < CW'(BORDER_W)) ||
                           ((right_c - hcnt_q)  < CW'(BORDER_W)) ||
                           ((vcnt_q - top_c)    < CW'(BORDER_W)) ||
                           ((bottom_c - vcnt_q) < CW'(BORDER_W));
        assign hit_c[gi] = sh_en_q[gi] && in_box_c && (!sh_mode_q[gi] || on_edge_c);
    end

    // Priority compositor: walk high to low so the lowest-index hit is applied last.
    always_comb begin
        pix_c = {bus.VGA_R_IN, bus.VGA_G_IN, bus.VGA_B_IN};
        for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                pix_c = sh_color_q[24*i +: 24];
            end
        end
        rgb_d = active_c ? pix_c : '0;
    end

    // Counters, output stage and frame-synchronous shadow registers.
    always_ff @(posedge VGA_CLK) begin
        if (!RESET_N) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            rgb_q       <= '0;
            blank_n_q   <= 1'b0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            req_q       <= 1'b0;
            fs_q        <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            sh_en_q     <= '0;
            sh_mode_q   <= '0;
            sh_left_q   <= '0;
            sh_top_q    <= '0;
            sh_right_q  <= '0;
            sh_bottom_q <= '0;
            sh_color_q  <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            rgb_q     <= rgb_d;
            blank_n_q <= blank_n_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            req_q     <= req_d;
            fs_q      <= fs_d;
            sx_q      <= hcnt_q;
            sy_q      <= vcnt_q;
            if (frame_end_c) begin
                sh_en_q     <= bus.BOX_ENABLE;
                sh_mode_q   <= bus.BOX_MODE;
                sh_left_q   <= bus.BOX_LEFT;
                sh_top_q    <= bus.BOX_TOP;
                sh_right_q  <= bus.BOX_RIGHT;
                sh_bottom_q <= bus.BOX_BOTTOM;
                sh_color_q  <= bus.BOX_COLOR;
            end
        end
    end

    assign bus.VGA_R        = rgb_q[23:16];
    assign bus.VGA_G        = rgb_q[15:8];
    assign bus.VGA_B        = rgb_q[7:0];
    assign bus.VGA_BLANK_N  = blank_n_q;
    assign bus.VGA_SYNC_N   = 1'b0;
    assign bus.VGA_HS       = hs_q;
    assign bus.VGA_VS       = vs_q;
    assign bus.REQUEST_DATA = req_q;
    assign bus.SCREEN_X     = sx_q;
    assign bus.SCREEN_Y     = sy_q;
    assign bus.FRAME_START  = fs_q;

endmodule
